fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end sitting directly downstream of the branch predictor. It owns the fetch PC, drives it to the predictor and instruction memory, and advances it to the predictor's `pc_pre` each cycle it can accept an instruction. Each fetched instruction, with its prediction metadata, goes into a small FIFO toward decode. An EX-stage misprediction redirect flushes the FIFO and restarts fetch at the corrected PC. Addresses are word addresses: sequential next PC is PC+1.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `RESET_PC`, 32'h0: fetch PC after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `pc_now`  out  32  current fetch PC, to the predictor lookup and the instruction memory address.
- `instr`  in  32  instruction memory read data for `pc_now`, valid in the same cycle (combinational read).
- `pc_pre`  in  32  predictor's next-PC for `pc_now`: either the predicted target or `pc_now`+1.
- `hit`  in  1  predictor table hit for `pc_now`.
- `hitpos`  in  3  predictor entry index for `pc_now`; meaningful only when `hit`=1.
- `redirect`  in  1  EX-stage misprediction or correction request.
- `redirect_pc`  in  32  correct next PC; sampled when `redirect`=1.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `out_pc`  out  32  head entry fetch PC.
- `out_instr`  out  32  head entry instruction.
- `out_pred_pc`  out  32  head entry predicted next PC; EX compares it with the resolved next PC.
- `out_hit`  out  1  head entry predictor hit, carried to EX for the predictor update.
- `out_hitpos`  out  3  head entry predictor index, carried to EX for the predictor update.
- `count`  out  $clog2(DEPTH)+1  current number of occupied entries.

## Operation
- State:
  - PC register `pc_now`.
  - DEPTH-entry storage array; each entry holds {pc, instr, pred_pc, hit, hitpos}.
  - Write pointer `wp`, read pointer `rp` (log2 DEPTH bits each, wrapping modulo DEPTH).
  - `count`.
- `pop` = `out_valid` & `out_ready`.
- `push` = ~`redirect` & ((`count` < DEPTH) | `pop`). A full queue still fetches when it is popped in the same cycle.
- `out_valid` = (`count` != 0) & ~`redirect`. It is combinational: a redirect cycle never hands an entry to decode.
- Payload outputs show the entry at `rp`. Their value while `out_valid`=0 is don't-care; the implementation drives the stored slot contents.
- On `push`:
  - Write {`pc_now`, `instr`, `pc_pre`, `hit`, `hitpos`} at `wp`.
  - `wp` <= `wp`+1.
  - `pc_now` <= `pc_pre`.
- On `pop`: `rp` <= `rp`+1.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- No push (full, no pop): `pc_now` holds. The predictor is re-consulted on the same PC next cycle.
- On `redirect` (highest priority):
  - `wp`, `rp`, `count` <= 0.
  - `pc_now` <= `redirect_pc`.
  - No push and no pop this cycle.
  - Storage contents need not be cleared.
- `pc_pre` is never recomputed internally. The block trusts the predictor, including its wrap at 32'hFFFFFFFF+1 = 0.

## Timing
- Reset (asynchronous on `rst` low):
  - `pc_now` = `RESET_PC`.
  - `wp` = `rp` = 0, `count` = 0.
  - All storage = 0.
  - Hence `out_valid` = 0 and every payload output = 0.
- First rising edge after `rst` deasserts: fetch of `RESET_PC` is pushed.
- Fetch-to-decode latency: an entry pushed at edge N has `out_valid`=1 from edge N until popped. That is one cycle from `pc_now` presentation; no combinational path from `instr` to `out_*`.
- Redirect latency: `redirect` high in cycle N means `pc_now` = `redirect_pc` after edge N. Its first instruction is visible at `out_*` after edge N+1.
- Steady state with `out_ready`=1: one push and one pop per cycle, `count` constant.
- Boundaries:
  - Empty with push: pop impossible (`out_valid`=0).
  - Full without pop: push suppressed, `pc_now` stable.
  - Pointer wrap from DEPTH−1 to 0 is seamless.
  - `redirect` together with `out_ready`: no pop.
  - `redirect` held multiple cycles: queue stays empty, `pc_now` follows `redirect_pc` each cycle.

## Test plan
- Reset, then predictor returns `pc_pre`=`pc_now`+1, `out_ready`=1 -> `out_valid` rises one cycle after reset release, `out_pc` = 0,1,2,3… on consecutive cycles, `count` stays 1.
- `out_ready`=0 for 6 cycles from reset -> `count` reaches 4 after 4 pushes, then `pc_now` holds at 4. Raise `out_ready` -> `out_pc` = 0,1,2,3,4 in order; `pc_now` resumes advancing in the first pop cycle.
- At `pc_now`=5, drive `hit`=1, `hitpos`=3, `pc_pre`=20 -> the entry with `out_pc`=5 shows `out_pred_pc`=20, `out_hit`=1, `out_hitpos`=3; the next entry has `out_pc`=20.
- With queue holding 3 entries, pulse `redirect`=1 with `redirect_pc`=100 and `out_ready`=1 -> `out_valid`=0 that cycle, `count`=0 after the edge, `pc_now`=100, next `out_pc`=100 one cycle later.
- Full queue with `out_ready`=1 for DEPTH·3 cycles -> one push and one pop per cycle, pointers wrap, FIFO order preserved, `count`=4 throughout.
- Assert `rst` low mid-stream with 2 entries queued -> immediately `out_valid`=0, `count`=0, `pc_now`=`RESET_PC`, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner and prediction-tagged instruction FIFO toward decode
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              pc_now,
    input  logic [31:0]              instr,
    input  logic [31:0]              pc_pre,
    input  logic                     hit,
    input  logic [2:0]               hitpos,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pred_pc,
    output logic                     out_hit,
    output logic [2:0]               out_hitpos,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred_pc;
        logic        hit;
        logic [2:0]  hitpos;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [31:0]     pc_q, pc_d;
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, push, pop;

    assign full      = (count_q == CW'(DEPTH));
    // A redirect cycle hides the head so decode never consumes a squashed entry.
    assign out_valid = (count_q != '0) & ~redirect;
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect & (~full | pop);

    always_comb begin
        pc_d    = pc_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + AW'(1);
                pc_d = pc_pre;
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wp_q] <= {pc_q, instr, pc_pre, hit, hitpos};
            end
        end
    end

    assign head        = mem_q[rp_q];
    assign pc_now      = pc_q;
    assign count       = count_q;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign out_pred_pc = head.pred_pc;
    assign out_hit     = head.hit;
    assign out_hitpos  = head.hitpos;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] pc_now;
    logic [31:0] instr;
    logic [31:0] pc_pre;
    logic        hit;
    logic [2:0]  hitpos;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pred_pc;
    logic        out_hit;
    logic [2:0]  out_hitpos;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc_now(pc_now), .instr(instr), .pc_pre(pc_pre),
        .hit(hit), .hitpos(hitpos), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_pred_pc(out_pred_pc), .out_hit(out_hit),
        .out_hitpos(out_hitpos), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pre;
        logic        h;
        logic [2:0]  hp;
    } ref_entry_t;

    ref_entry_t  ref_q [$];
    logic [31:0] ref_pc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a rising edge; drives one cycle, checks, advances the model.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc,
                         input logic tgt_en, input logic [31:0] tgt,
                         input logic h, input logic [2:0] hp);
        logic       exp_valid;
        ref_entry_t e;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        instr       = $urandom;
        pc_pre      = tgt_en ? tgt : ref_pc + 32'd1;
        hit         = h;
        hitpos      = hp;
        #3;
        exp_valid = (ref_q.size() != 0) && !rd;
        check("pc_now", pc_now, ref_pc);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("count", 32'(count), 32'(ref_q.size()));
        if (exp_valid) begin
            check("out_pc", out_pc, ref_q[0].pc);
            check("out_instr", out_instr, ref_q[0].ins);
            check("out_pred_pc", out_pred_pc, ref_q[0].pre);
            check("out_hit", 32'(out_hit), 32'(ref_q[0].h));
            check("out_hitpos", 32'(out_hitpos), 32'(ref_q[0].hp));
        end
        if (rd) begin
            ref_q.delete();
            ref_pc = rpc;
        end else begin
            if (exp_valid && rdy) void'(ref_q.pop_front());
            if (ref_q.size() < int'(DEPTH)) begin
                e.pc  = ref_pc;
                e.ins = instr;
                e.pre = pc_pre;
                e.h   = h;
                e.hp  = hp;
                ref_q.push_back(e);
                ref_pc = pc_pre;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_pc_now"}, pc_now, RESET_PC);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_pred_pc"}, out_pred_pc, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr       = 32'h0;
        pc_pre      = 32'h0;
        hit         = 1'b0;
        hitpos      = 3'd0;
        rst         = 1'b1;
        #2 rst = 1'b0;
        #1;
        reset_checks("reset");
        @(posedge clk);
        #1;
        rst    = 1'b1;
        ref_pc = RESET_PC;
        ref_q.delete();

        seq(6, 1'b0);
        seq(8, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'd20, 1'b1, 3'd3);
        seq(6, 1'b1);

        seq(5, 1'b0);
        seq(3 * DEPTH, 1'b1);

        cycle(1'b0, 1'b1, 32'd50, 1'b0, 32'h0, 1'b0, 3'd0);
        seq(3, 1'b0);
        cycle(1'b1, 1'b1, 32'd100, 1'b0, 32'h0, 1'b0, 3'd0);
        seq(4, 1'b1);

        cycle(1'b1, 1'b1, 32'd7, 1'b0, 32'h0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 3'd0);
        seq(4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom,
                  ($urandom % 4) == 0, $urandom, 1'($urandom), 3'($urandom));
        end

        cycle(1'b0, 1'b1, 32'd200, 1'b0, 32'h0, 1'b0, 3'd0);
        seq(2, 1'b0);
        #2 rst = 1'b0;
        #1;
        reset_checks("async_rst");
        ref_q.delete();
        ref_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seq(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
